// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel tick strobes,
// a shared sync restart and a single-slot divisor load handshake.
module clk_div_multi #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable_in,
  input  logic              sync_in,
  input  logic [CH_W-1:0]   ch_sel_in,
  input  logic [DIV_W-1:0]  div_in,
  input  logic              div_valid_in,
  output logic              div_ready_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick_out
);

  localparam logic [DIV_W-1:0] DEF_D   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_CNT = DIV_W'(DEFAULT_DIV - 1);

  logic              pend_vld;
  logic [CH_W-1:0]   pend_ch;
  logic [DIV_W-1:0]  pend_div;
  logic [NUM_CH-1:0] apply;
  logic              load;
  logic              sel_ok;

  assign div_ready_out = ~pend_vld;
  assign load          = div_valid_in & div_ready_out;
  assign sel_ok        = 32'(ch_sel_in) < 32'(NUM_CH);

  // Out-of-range selects complete the handshake but never occupy the slot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_vld <= 1'b0;
      pend_ch  <= '0;
      pend_div <= '0;
    end else if (|apply) begin
      pend_vld <= 1'b0;
    end else if (load && sel_ok) begin
      pend_vld <= 1'b1;
      pend_ch  <= ch_sel_in;
      pend_div <= div_in;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             clk_q;
    logic             tick_q;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] cnt_d;
    logic             clk_d;
    logic             tick_d;
    logic             apply_c;
    logic             mine;

    assign half     = div_q - (div_q >> 1);
    assign mine     = pend_vld && (pend_ch == CH_W'(i));
    assign apply[i] = apply_c;
    assign clk_out[i]  = clk_q;
    assign tick_out[i] = tick_q;

    always_comb begin
      cnt_nxt = (cnt_q == div_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
      div_d   = div_q;
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      apply_c = 1'b0;
      if (div_q == '0) begin
        cnt_d   = '0;
        clk_d   = 1'b0;
        apply_c = mine;
      end else if (sync_in) begin
        cnt_d   = '0;
        clk_d   = 1'b1;
        tick_d  = 1'b1;
        apply_c = mine;
      end else if (enable_in) begin
        cnt_d   = cnt_nxt;
        clk_d   = cnt_nxt < half;
        tick_d  = cnt_nxt == '0;
        apply_c = mine && (cnt_nxt == '0);
      end
      // Every apply lands on a cnt = 0 edge, so outputs depend only on the new D.
      if (apply_c) begin
        div_d  = pend_div;
        cnt_d  = '0;
        clk_d  = pend_div != '0;
        tick_d = pend_div != '0;
      end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        div_q  <= DEF_D;
        cnt_q  <= DEF_CNT;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        div_q  <= div_d;
        cnt_q  <= cnt_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: defaults, runtime loads, halt, enable,
// sync alignment and asynchronous reset with a pending load.
module tb_clk_div_multi;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       enable_in;
  logic       sync_in;
  logic [0:0] ch_sel_in;
  logic [7:0] div_in;
  logic       div_valid_in;
  logic       div_ready_out;
  logic [1:0] clk_out;
  logic [1:0] tick_out;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(
    .NUM_CH(2),
    .DIV_W(8),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .enable_in(enable_in),
    .sync_in(sync_in),
    .ch_sel_in(ch_sel_in),
    .div_in(div_in),
    .div_valid_in(div_valid_in),
    .div_ready_out(div_ready_out),
    .clk_out(clk_out),
    .tick_out(tick_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load_div(input logic [0:0] ch, input logic [7:0] d);
    ch_sel_in    = ch;
    div_in       = d;
    div_valid_in = 1'b1;
    step();
    div_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] ec [0:8] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    logic [1:0] et [0:8] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    rst_in = 1'b0; enable_in = 1'b1; sync_in = 1'b0;
    ch_sel_in = '0; div_in = '0; div_valid_in = 1'b0;
    step(); step();
    checks++; if (clk_out !== 2'b00) begin errors++; $display("FAIL reset_clk got=%b exp=00", clk_out); end
    checks++; if (tick_out !== 2'b00) begin errors++; $display("FAIL reset_tick got=%b exp=00", tick_out); end
    checks++; if (div_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", div_ready_out); end
    rst_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++; if (clk_out !== ec[k]) begin errors++; $display("FAIL default_clk edge=%0d got=%b exp=%b", k + 1, clk_out, ec[k]); end
      checks++; if (tick_out !== et[k]) begin errors++; $display("FAIL default_tick edge=%0d got=%b exp=%b", k + 1, tick_out, et[k]); end
    end
  endtask

  task automatic test_load_mid();
    logic [1:0] ec [0:5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [1:0] et [0:5] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    step(); step();
    checks++; if (div_ready_out !== 1'b1) begin errors++; $display("FAIL load_ready_idle got=%b exp=1", div_ready_out); end
    load_div(1'b1, 8'd5);
    checks++; if (div_ready_out !== 1'b0) begin errors++; $display("FAIL load_ready_pending got=%b exp=0", div_ready_out); end
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) begin
        checks++; if (div_ready_out !== 1'b1) begin errors++; $display("FAIL load_ready_applied got=%b exp=1", div_ready_out); end
      end
      checks++; if (clk_out !== ec[k]) begin errors++; $display("FAIL d5_clk k=%0d got=%b exp=%b", k, clk_out, ec[k]); end
      checks++; if (tick_out !== et[k]) begin errors++; $display("FAIL d5_tick k=%0d got=%b exp=%b", k, tick_out, et[k]); end
    end
  endtask

  task automatic test_halt();
    logic ec [0:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic et [0:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load_div(1'b0, 8'd0);
    checks++; if (div_ready_out !== 1'b0) begin errors++; $display("FAIL halt_ready_pending got=%b exp=0", div_ready_out); end
    step(); step();
    checks++; if (div_ready_out !== 1'b1) begin errors++; $display("FAIL halt_ready_applied got=%b exp=1", div_ready_out); end
    checks++; if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL halt_clk_wrap got=%b exp=0", clk_out[0]); end
    checks++; if (tick_out[0] !== 1'b0) begin errors++; $display("FAIL halt_tick_wrap got=%b exp=0", tick_out[0]); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL halt_hold k=%0d got=%b exp=0", k, clk_out[0]); end
    end
    load_div(1'b0, 8'd6);
    checks++; if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL halt_capture_clk got=%b exp=0", clk_out[0]); end
    for (int k = 0; k < 7; k++) begin
      step();
      checks++; if (clk_out[0] !== ec[k]) begin errors++; $display("FAIL d6_clk k=%0d got=%b exp=%b", k, clk_out[0], ec[k]); end
      checks++; if (tick_out[0] !== et[k]) begin errors++; $display("FAIL d6_tick k=%0d got=%b exp=%b", k, tick_out[0], et[k]); end
    end
  endtask

  task automatic test_enable();
    step();
    checks++; if (clk_out !== 2'b01) begin errors++; $display("FAIL en_pre_clk got=%b exp=01", clk_out); end
    enable_in = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      checks++; if (clk_out !== 2'b01) begin errors++; $display("FAIL en_hold_clk k=%0d got=%b exp=01", k, clk_out); end
      checks++; if (tick_out !== 2'b00) begin errors++; $display("FAIL en_hold_tick k=%0d got=%b exp=00", k, tick_out); end
    end
    enable_in = 1'b1;
    step();
    checks++; if (clk_out !== 2'b11) begin errors++; $display("FAIL en_resume_clk got=%b exp=11", clk_out); end
    checks++; if (tick_out !== 2'b10) begin errors++; $display("FAIL en_resume_tick got=%b exp=10", tick_out); end
    step();
    checks++; if (clk_out !== 2'b10) begin errors++; $display("FAIL en_resume2_clk got=%b exp=10", clk_out); end
  endtask

  task automatic test_sync();
    logic [1:0] ec [0:8] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11};
    logic [1:0] et [0:8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11};
    int n;
    load_div(1'b0, 8'd3);
    n = 0;
    while (div_ready_out !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (div_ready_out !== 1'b1) begin errors++; $display("FAIL sync_load_ch0_timeout ready=%b exp=1", div_ready_out); end
    load_div(1'b1, 8'd7);
    n = 0;
    while (div_ready_out !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (div_ready_out !== 1'b1) begin errors++; $display("FAIL sync_load_ch1_timeout ready=%b exp=1", div_ready_out); end
    enable_in = 1'b0;
    load_div(1'b1, 8'd9);
    checks++; if (div_ready_out !== 1'b0) begin errors++; $display("FAIL sync_pending got=%b exp=0", div_ready_out); end
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    enable_in = 1'b1;
    checks++; if (clk_out !== 2'b11) begin errors++; $display("FAIL sync_clk got=%b exp=11", clk_out); end
    checks++; if (tick_out !== 2'b11) begin errors++; $display("FAIL sync_tick got=%b exp=11", tick_out); end
    checks++; if (div_ready_out !== 1'b1) begin errors++; $display("FAIL sync_apply_ready got=%b exp=1", div_ready_out); end
    for (int k = 0; k < 9; k++) begin
      step();
      checks++; if (clk_out !== ec[k]) begin errors++; $display("FAIL post_sync_clk k=%0d got=%b exp=%b", k, clk_out, ec[k]); end
      checks++; if (tick_out !== et[k]) begin errors++; $display("FAIL post_sync_tick k=%0d got=%b exp=%b", k, tick_out, et[k]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ec [0:4] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    logic [1:0] et [0:4] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    load_div(1'b0, 8'd5);
    checks++; if (clk_out !== 2'b11) begin errors++; $display("FAIL rmid_pre_clk got=%b exp=11", clk_out); end
    checks++; if (div_ready_out !== 1'b0) begin errors++; $display("FAIL rmid_pre_ready got=%b exp=0", div_ready_out); end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (clk_out !== 2'b00) begin errors++; $display("FAIL rmid_async_clk got=%b exp=00", clk_out); end
    checks++; if (tick_out !== 2'b00) begin errors++; $display("FAIL rmid_async_tick got=%b exp=00", tick_out); end
    checks++; if (div_ready_out !== 1'b1) begin errors++; $display("FAIL rmid_async_ready got=%b exp=1", div_ready_out); end
    rst_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (clk_out !== ec[k]) begin errors++; $display("FAIL rmid_clk edge=%0d got=%b exp=%b", k + 1, clk_out, ec[k]); end
      checks++; if (tick_out !== et[k]) begin errors++; $display("FAIL rmid_tick edge=%0d got=%b exp=%b", k + 1, tick_out, et[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_mid();
    test_halt();
    test_enable();
    test_sync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
